// File: rtl/instr_decode_ctrl.sv
// -----------------------------------------------------------------------------
// instr_decode_ctrl
//
// Multi-cycle decode/sequence stage in front of the datapath. It accepts one
// RV32 R-type instruction per valid/ready handshake and decodes it into
// register indices and an ALU opcode. The FSM then holds those fields steady
// while the datapath executes, and pulses the register-file write enable for
// exactly one cycle in write-back.
//
// Sequence: IDLE -> DECODE -> EXEC (1 cycle, or DIV_CYCLES for DIV) -> WB -> IDLE
// An unsupported instruction goes DECODE -> IDLE, raises `illegal` for one
// cycle and never writes.
//
// Parameters
//   DIV_CYCLES     number of EXEC cycles spent on a DIV (>= 1)
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset          synchronous, active-high reset; aborts any instruction
//   instr_valid    upstream presents a word on `instr`
//   instr          32-bit RV32 instruction word
//   instr_ready    high in IDLE while reset is low (combinational)
//   zero_flag      datapath zero flag, sampled at the end of WB
//   rs1, rs2       source register indices, valid from DECODE onward
//   rw             destination register index, updated on entry to WB
//   operation      ALU opcode (ADD/SUB/AND/OR/DIV macro values, 0 if illegal)
//   write          register-file write enable, one-cycle pulse in WB
//   busy           high in any state other than IDLE (combinational)
//   illegal        one-cycle pulse in DECODE for a rejected instruction
//   retired        one-cycle pulse in WB
//   zero_q         zero_flag captured at the end of the last WB
//
// Optional feature (macro DECODE_PERF_CNT_EN)
//   retire_count   16-bit wrapping count of `retired` pulses
//   illegal_count  16-bit wrapping count of `illegal` pulses
//   When the macro is undefined these ports and counters do not exist.
// -----------------------------------------------------------------------------

// ALU opcode values shared with the datapath. Normally supplied by the
// project-wide constants file; the guarded defaults keep this file standalone.
`ifndef ADD
`define ADD 7'h01
`endif
`ifndef SUB
`define SUB 7'h02
`endif
`ifndef AND
`define AND 7'h03
`endif
`ifndef OR
`define OR  7'h04
`endif
`ifndef DIV
`define DIV 7'h05
`endif

module instr_decode_ctrl #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        zero_flag,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rw,
  output logic [6:0]  operation,
  output logic        write,
  output logic        busy,
  output logic        illegal,
  output logic        retired,
  output logic        zero_q
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [15:0] retire_count,
  output logic [15:0] illegal_count
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  // {funct7, funct3} keys of the supported R-type operations.
  localparam logic [9:0] FN_ADD = {7'b0000000, 3'b000};
  localparam logic [9:0] FN_SUB = {7'b0100000, 3'b000};
  localparam logic [9:0] FN_AND = {7'b0000000, 3'b111};
  localparam logic [9:0] FN_OR  = {7'b0000000, 3'b110};
  localparam logic [9:0] FN_DIV = {7'b0000001, 3'b100};

  // Wide enough to hold DIV_CYCLES itself.
  localparam int               CNT_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rw_pending;   // destination index held until WB

  logic             handshake;
  logic             dec_legal;
  logic [6:0]       dec_op;

  // ---------------------------------------------------------------------------
  // Handshake and state-derived outputs
  // ---------------------------------------------------------------------------
  // Gating with reset keeps upstream from seeing a transfer on an edge where
  // the FSM is being forced back to IDLE anyway.
  assign instr_ready = (state == S_IDLE) && !reset;
  assign busy        = (state != S_IDLE);
  assign handshake   = instr_valid && instr_ready;

  // ---------------------------------------------------------------------------
  // Instruction decode (from the word presented at the handshake)
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 7'd0;
    if (instr[6:0] == OPCODE_OP) begin
      case ({instr[31:25], instr[14:12]})
        FN_ADD: begin dec_legal = 1'b1; dec_op = `ADD; end
        FN_SUB: begin dec_legal = 1'b1; dec_op = `SUB; end
        FN_AND: begin dec_legal = 1'b1; dec_op = `AND; end
        FN_OR:  begin dec_legal = 1'b1; dec_op = `OR;  end
        FN_DIV: begin dec_legal = 1'b1; dec_op = `DIV; end
        default: begin
          dec_legal = 1'b0;
          dec_op    = 7'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pending destination register
  // ---------------------------------------------------------------------------
  // NOTE: pure data holding register with no reset: it is only consumed after
  // a handshake has loaded it, so its power-up value never reaches an output.
  always_ff @(posedge clk) begin
    if (handshake) begin
      rw_pending <= instr[11:7];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rw        <= 5'd0;
      operation <= 7'd0;
      write     <= 1'b0;
      illegal   <= 1'b0;
      retired   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      // Pulses default low; the arms below raise them for a single cycle.
      write   <= 1'b0;
      illegal <= 1'b0;
      retired <= 1'b0;

      case (state)
        S_IDLE: begin
          if (handshake) begin
            state     <= S_DECODE;
            // Sources and opcode become visible in the DECODE cycle and then
            // stay put until the next accepted instruction.
            rs1       <= instr[19:15];
            rs2       <= instr[24:20];
            operation <= dec_op;
            illegal   <= !dec_legal;
          end
        end

        S_DECODE: begin
          // `illegal` is high exactly during DECODE of a rejected word.
          if (illegal) begin
            state <= S_IDLE;
          end else begin
            state <= S_EXEC;
            cnt   <= (operation == `DIV) ? CNT_DIV : CNT_ONE;
          end
        end

        S_EXEC: begin
          // The `<=` compare also covers a zero count, so the counter can
          // never wrap below zero.
          if (cnt <= CNT_ONE) begin
            state   <= S_WB;
            cnt     <= '0;
            rw      <= rw_pending;
            write   <= (rw_pending != 5'd0);  // x0 is hard-wired, never written
            retired <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_WB: begin
          // The datapath result settles during WB; capture its flag as we leave.
          state  <= S_IDLE;
          zero_q <= zero_flag;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters: one count per observed pulse, free-running wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count  <= 16'd0;
      illegal_count <= 16'd0;
    end else begin
      if (retired) begin
        retire_count <= retire_count + 16'd1;
      end
      if (illegal) begin
        illegal_count <= illegal_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_ctrl
//
// Self-checking bench for instr_decode_ctrl. A reference model derives, from
// the decode table and the latency rules, what every output must be on each
// cycle after an instruction is accepted; the bench compares the DUT cycle by
// cycle. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------

`ifndef ADD
`define ADD 7'h01
`endif
`ifndef SUB
`define SUB 7'h02
`endif
`ifndef AND
`define AND 7'h03
`endif
`ifndef OR
`define OR  7'h04
`endif
`ifndef DIV
`define DIV 7'h05
`endif

module tb_instr_decode_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int PERIOD     = 10;

  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr       = 32'd0;
  logic        zero_flag   = 1'b0;
  logic        instr_ready;
  logic [4:0]  rs1, rs2, rw;
  logic [6:0]  operation;
  logic        write, busy, illegal, retired, zero_q;
`ifdef DECODE_PERF_CNT_EN
  logic [15:0] retire_count, illegal_count;
`endif

  instr_decode_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .zero_flag   (zero_flag),
    .rs1         (rs1),
    .rs2         (rs2),
    .rw          (rw),
    .operation   (operation),
    .write       (write),
    .busy        (busy),
    .illegal     (illegal),
    .retired     (retired),
    .zero_q      (zero_q)
`ifdef DECODE_PERF_CNT_EN
    ,
    .retire_count  (retire_count),
    .illegal_count (illegal_count)
`endif
  );

  always #(PERIOD / 2) clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed output vector per cycle after acceptance (index 1 = DECODE cycle).
  // Layout: {instr_ready, busy, rs1, rs2, rw, operation, write, illegal, retired, zero_q}
  logic [27:0] obs [0:15];

  // Architectural state the model carries between instructions.
  logic [4:0] m_rw  = 5'd0;
  logic       m_zq  = 1'b0;
  int         m_ret = 0;
  int         m_ill = 0;

  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [6:0] op;
  } rtype_t;

  rtype_t op_table [5] = '{
    '{7'b0000000, 3'b000, `ADD},
    '{7'b0100000, 3'b000, `SUB},
    '{7'b0000000, 3'b111, `AND},
    '{7'b0000000, 3'b110, `OR},
    '{7'b0000001, 3'b100, `DIV}
  };

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void ref_decode(input logic [31:0] w, output logic legal,
                                     output logic [6:0] op);
    legal = 1'b0;
    op    = 7'd0;
    if (w[6:0] == 7'h33) begin
      foreach (op_table[i]) begin
        if (op_table[i].f7 == w[31:25] && op_table[i].f3 == w[14:12]) begin
          legal = 1'b1;
          op    = op_table[i].op;
        end
      end
    end
  endfunction

  // Cycle index (after acceptance) of write-back; 0 for a rejected word.
  function automatic int wb_index(input logic [31:0] w);
    logic legal;
    logic [6:0] op;
    ref_decode(w, legal, op);
    if (!legal) return 0;
    return 2 + ((op == `DIV) ? DIV_CYCLES : 1);
  endfunction

  // Cycles to observe: through the first IDLE cycle after the instruction.
  function automatic int exp_len(input logic [31:0] w);
    int wb;
    wb = wb_index(w);
    return (wb == 0) ? 2 : wb + 1;
  endfunction

  function automatic logic [27:0] exp_obs(input int k, input logic [31:0] w,
                                          input logic zf, input logic [4:0] prw,
                                          input logic pzq);
    logic legal;
    logic [6:0] op;
    int wb;
    ref_decode(w, legal, op);
    wb = wb_index(w);
    if (!legal) begin
      if (k == 1) return {1'b0, 1'b1, w[19:15], w[24:20], prw, 7'd0, 1'b0, 1'b1, 1'b0, pzq};
      return {1'b1, 1'b0, w[19:15], w[24:20], prw, 7'd0, 1'b0, 1'b0, 1'b0, pzq};
    end
    if (k < wb)  return {1'b0, 1'b1, w[19:15], w[24:20], prw, op, 1'b0, 1'b0, 1'b0, pzq};
    if (k == wb) return {1'b0, 1'b1, w[19:15], w[24:20], w[11:7], op,
                         (w[11:7] != 5'd0), 1'b0, 1'b1, pzq};
    return {1'b1, 1'b0, w[19:15], w[24:20], w[11:7], op, 1'b0, 1'b0, 1'b0, zf};
  endfunction

  function automatic void model_commit(input logic [31:0] w, input logic zf);
    logic legal;
    logic [6:0] op;
    ref_decode(w, legal, op);
    if (legal) begin
      m_rw = w[11:7];
      m_zq = zf;
      m_ret++;
    end else begin
      m_ill++;
    end
  endfunction

  function automatic void model_reset();
    m_rw  = 5'd0;
    m_zq  = 1'b0;
    m_ret = 0;
    m_ill = 0;
  endfunction

  function automatic logic [27:0] pack_obs();
    return {instr_ready, busy, rs1, rs2, rw, operation, write, illegal, retired, zero_q};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus: present one word and record outputs for each following cycle.
  // zero_flag carries `zf` only in the second half of the WB cycle so the
  // capture edge is pinned down. With `junk`, instr_valid stays high with
  // random words while the block is busy; those must be ignored.
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [31:0] word, input logic zf, input bit junk,
                       output int n, output time t_acc);
    int waited = 0;
    int wb;
    n  = exp_len(word);
    wb = wb_index(word);
    while (instr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready_timeout instr_ready=%b required=1", instr_ready);
    end
    t_acc       = $time;
    instr       = word;
    instr_valid = 1'b1;
    zero_flag   = ~zf;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      obs[k]      = pack_obs();
      instr_valid = junk && (k < n);
      if (junk) instr = $urandom();
      zero_flag   = (k == wb) ? zf : ~zf;
    end
    instr_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [27:0] exp;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp = 28'd0;
    checks++;
    if (pack_obs() !== exp) begin
      failures++;
      $display("FAIL reset_held got=%h required=%h", pack_obs(), exp);
    end
    reset = 1'b0;
    model_reset();
    #1;
    exp = {1'b1, 27'd0};
    checks++;
    if (pack_obs() !== exp) begin
      failures++;
      $display("FAIL reset_release got=%h required=%h", pack_obs(), exp);
    end
    @(negedge clk);
    checks++;
    if (pack_obs() !== exp) begin
      failures++;
      $display("FAIL reset_idle got=%h required=%h", pack_obs(), exp);
    end
  endtask

  task automatic test_add();
    logic [31:0] w = 32'h01B283B3;
    logic [27:0] exp;
    int n;
    time t;
    issue(w, 1'b0, 1'b0, n, t);
    for (int k = 1; k <= n; k++) begin
      exp = exp_obs(k, w, 1'b0, m_rw, m_zq);
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL add cycle=%0d got=%h required=%h", k, obs[k], exp);
      end
    end
    model_commit(w, 1'b0);
  endtask

  task automatic test_sub_zero();
    logic [31:0] w = 32'h417701B3;
    logic [27:0] exp;
    int n;
    time t;
    issue(w, 1'b1, 1'b0, n, t);
    for (int k = 1; k <= n; k++) begin
      exp = exp_obs(k, w, 1'b1, m_rw, m_zq);
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL sub_zero cycle=%0d got=%h required=%h", k, obs[k], exp);
      end
    end
    model_commit(w, 1'b1);
  endtask

  task automatic test_div();
    logic [31:0] w = 32'h035144B3;
    logic [27:0] exp;
    int n;
    time t;
    issue(w, 1'b0, 1'b0, n, t);
    for (int k = 1; k <= n; k++) begin
      exp = exp_obs(k, w, 1'b0, m_rw, m_zq);
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL div cycle=%0d got=%h required=%h", k, obs[k], exp);
      end
    end
    model_commit(w, 1'b0);
  endtask

  task automatic test_div_reset();
    logic [31:0] w = 32'h035144B3;
    logic [27:0] exp;
    logic [27:0] got;
    int waited = 0;
    while (instr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    instr       = w;
    instr_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      got = pack_obs();
      exp = exp_obs(k, w, 1'b0, m_rw, m_zq);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL div_abort_pre cycle=%0d got=%h required=%h", k, got, exp);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    got = pack_obs();
    checks++;
    if (got !== 28'd0) begin
      failures++;
      $display("FAIL div_abort_reset got=%h required=%h", got, 28'd0);
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < DIV_CYCLES + 2; k++) begin
      @(negedge clk);
      got = pack_obs();
      exp = {1'b1, 27'd0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL div_abort_idle cycle=%0d got=%h required=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w = 32'h00000013;
    logic [27:0] exp;
    int n;
    time t;
    issue(w, 1'b1, 1'b0, n, t);
    for (int k = 1; k <= n; k++) begin
      exp = exp_obs(k, w, 1'b1, m_rw, m_zq);
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL illegal cycle=%0d got=%h required=%h", k, obs[k], exp);
      end
    end
    model_commit(w, 1'b1);
  endtask

  task automatic test_x0();
    logic [31:0] w = 32'h00208033;
    logic [27:0] exp;
    int n;
    time t;
    issue(w, 1'b1, 1'b0, n, t);
    for (int k = 1; k <= n; k++) begin
      exp = exp_obs(k, w, 1'b1, m_rw, m_zq);
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL x0 cycle=%0d got=%h required=%h", k, obs[k], exp);
      end
    end
    model_commit(w, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    logic [27:0] exp;
    logic        zf;
    int n;
    time t, t_prev;
    for (int i = 0; i < 4; i++) begin
      w  = {op_table[i].f7, 5'($urandom), 5'($urandom), op_table[i].f3,
            5'($urandom_range(1, 31)), 7'h33};
      zf = 1'($urandom);
      issue(w, zf, 1'b1, n, t);
      for (int k = 1; k <= n; k++) begin
        exp = exp_obs(k, w, zf, m_rw, m_zq);
        checks++;
        if (obs[k] !== exp) begin
          failures++;
          $display("FAIL b2b[%0d] cycle=%0d got=%h required=%h", i, k, obs[k], exp);
        end
      end
      model_commit(w, zf);
      if (i > 0) begin
        checks++;
        if ((t - t_prev) !== time'(4 * PERIOD)) begin
          failures++;
          $display("FAIL b2b_spacing[%0d] got=%0t required=%0t", i, t - t_prev,
                   time'(4 * PERIOD));
        end
      end
      t_prev = t;
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [27:0] exp;
    logic        zf;
    int sel, n;
    time t;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 6));
      if (sel < 5) begin
        w = {op_table[sel].f7, 5'($urandom), 5'($urandom), op_table[sel].f3,
             5'($urandom), 7'h33};
      end else if (sel == 5) begin
        w = {7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
      end else begin
        w = $urandom();
      end
      zf = 1'($urandom);
      issue(w, zf, 1'($urandom), n, t);
      for (int k = 1; k <= n; k++) begin
        exp = exp_obs(k, w, zf, m_rw, m_zq);
        checks++;
        if (obs[k] !== exp) begin
          failures++;
          $display("FAIL random[%0d] word=%h cycle=%0d got=%h required=%h", i, w, k, obs[k], exp);
        end
      end
      model_commit(w, zf);
    end
`ifdef DECODE_PERF_CNT_EN
    checks++;
    if (retire_count !== 16'(m_ret) || illegal_count !== 16'(m_ill)) begin
      failures++;
      $display("FAIL random_perf got=%0d/%0d required=%0d/%0d",
               retire_count, illegal_count, m_ret, m_ill);
    end
`endif
  endtask

`ifdef DECODE_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] words [5] = '{32'h01B283B3, 32'h00000013, 32'h417701B3,
                               32'hFFFFFFFF, 32'h035144B3};
    int n;
    time t;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if (retire_count !== 16'd0 || illegal_count !== 16'd0) begin
      failures++;
      $display("FAIL perf_reset got=%0d/%0d required=0/0", retire_count, illegal_count);
    end
    foreach (words[i]) begin
      issue(words[i], 1'b0, 1'b0, n, t);
      model_commit(words[i], 1'b0);
    end
    checks++;
    if (retire_count !== 16'(m_ret) || illegal_count !== 16'(m_ill)) begin
      failures++;
      $display("FAIL perf_count got=%0d/%0d required=%0d/%0d",
               retire_count, illegal_count, m_ret, m_ill);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_div();
    test_div_reset();
    test_illegal();
    test_x0();
    test_back_to_back();
    test_random();
`ifdef DECODE_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog simulation did not complete within %0d cycles", 20000);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
Multi-cycle decode/sequence stage directly upstream of the datapath. It accepts one 32-bit RV32 R-type instruction per transaction over a valid/ready handshake and decodes it into the datapath control fields `rs1`, `rs2`, `rw`, `operation` and `write`. An FSM holds those fields stable while the datapath executes, then pulses `write` for exactly one cycle. `operation` uses the shared ALU opcode macros in constants.v: `ADD, `SUB, `AND, `OR, `DIV.

Parameters:
- DIV_CYCLES, 4: number of EXEC cycles for `DIV`. Legal range ≥1. All other ops take 1 EXEC cycle.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  upstream has an instruction on `instr`
- instr  input  32  RV32 instruction word
- instr_ready  output  1  block can accept; high only in IDLE and with reset low
- zero_flag  input  1  zero flag from the datapath
- rs1  output  5  source register 1 index
- rs2  output  5  source register 2 index
- rw  output  5  destination register index
- operation  output  7  ALU opcode (constants.v macro value)
- write  output  1  register-file write enable, one-cycle pulse
- busy  output  1  high in any state other than IDLE
- illegal  output  1  one-cycle pulse when an unsupported instruction is rejected
- retired  output  1  one-cycle pulse in WB
- zero_q  output  1  `zero_flag` captured in WB of the last retired instruction

Behaviour:
- Reset (synchronous): state=IDLE; rs1, rs2, rw, operation, write, illegal, retired, zero_q, busy, and the cycle counter all go to 0.
- Reset mid-operation (any state) aborts the instruction; no write is issued.
- Output registering:
  - All outputs are registered except `instr_ready` and `busy`, which decode from state.
  - `instr_ready` is additionally gated by `!reset`.
- Handshake:
  - A transfer occurs on the edge where `instr_valid && instr_ready`. The word is latched and state goes to DECODE.
  - `instr_valid` is ignored while `instr_ready`=0; upstream holds the word.
- Decode table (opcode must be 7'b0110011, else illegal):
  - funct7=0000000, funct3=000 → `ADD
  - funct7=0100000, funct3=000 → `SUB
  - funct7=0000000, funct3=111 → `AND
  - funct7=0000000, funct3=110 → `OR
  - funct7=0000001, funct3=100 → `DIV
  - Any other opcode/funct combination is illegal.
- Field mapping: rs1=instr[19:15], rs2=instr[24:20], rw=instr[11:7].
- FSM transitions:
  - IDLE → DECODE on handshake.
  - DECODE: rs1, rs2 and operation are driven from this cycle onward. If illegal: `illegal`=1 for one cycle, operation=0, then → IDLE with no write and no `retired`. Else → EXEC and load the counter (DIV_CYCLES for `DIV`, 1 otherwise).
  - EXEC: fields held stable; counter decrements each cycle; → WB on the cycle the counter reaches 1.
  - WB: `write`=1 for exactly this cycle (0 if rw==0, since x0 is never written); `retired`=1; `zero_q` ← `zero_flag`; → IDLE.
  - On return to IDLE, rs1, rs2, rw and operation keep their last values; `write` returns to 0.
- Latency, counting from the acceptance edge T:
  - Non-DIV: DECODE at T+1, EXEC at T+2, WB (write high) at T+3, `instr_ready` high at T+4.
  - DIV: WB at T+2+DIV_CYCLES, `instr_ready` high at T+3+DIV_CYCLES.
  - Back-to-back throughput is therefore one instruction per 4 cycles (non-DIV).
- Counter width: $clog2(DIV_CYCLES+1); it never underflows.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined: adds output ports `retire_count` [15:0] and `illegal_count` [15:0].
  - They increment on `retired` and `illegal` pulses respectively.
  - Both wrap 0xFFFF→0 and reset to 0.
- When undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, `instr_ready`=1 in the first cycle after release.
- `instr`=0x01B283B3 (add x7,x5,x27) accepted at T → rs1=5, rs2=27, operation=`ADD from T+1; write=1, rw=7 only at T+3; `instr_ready`=1 at T+4.
- `instr`=0x417701B3 (sub x3,x14,x23), `zero_flag`=1 during WB → operation=`SUB, write pulse at T+3, zero_q=1 after WB, retired pulse once.
- DIV_CYCLES=4, `instr`=0x035144B3 (div x9,x2,x21) → operation=`DIV, write at T+6, `instr_ready`=0 from T through T+6. Repeat with reset asserted at T+3 → no write, state IDLE, all outputs 0 on the next edge.
- Illegal and x0 cases:
  - `instr`=0x00000013 → `illegal` pulse at T+1, never write/retired, `instr_ready`=1 at T+2.
  - `instr`=0x00208033 (add x0) → retired pulse, write stays 0.
- With DECODE_PERF_CNT_EN defined, 3 legal + 2 illegal instructions → retire_count=3, illegal_count=2.
